// File: rtl/xc_malu_long_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : xc_malu_long_seq
// Purpose  : Sequencer for the multi-cycle "long" arithmetic ops of the MALU
//            (madd, msub, macc, mmul). Owns the accumulator/carry registers
//            and issues one datapath micro-op strobe per micro-op cycle.
// Ports    :
//   g_clk, g_resetn            clock, asynchronous active-low reset
//   valid, flush               request (held until ready) and abort
//   op_madd/msub/macc/mmul     operation select, sampled on accept
//   mul_done, mul_product      multiplier handshake (mmul only)
//   n_accumulator, n_carry     next accumulator/carry from the datapath
//   uop_*                      micro-op strobes to the datapath
//   accumulator, carry         registered state driven to the datapath
//   ready, result              one-cycle completion pulse and result
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module xc_malu_long_seq (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic        flush,
  input  logic        op_madd,
  input  logic        op_msub,
  input  logic        op_macc,
  input  logic        op_mmul,
  input  logic        mul_done,
  input  logic [63:0] mul_product,
  input  logic [63:0] n_accumulator,
  input  logic        n_carry,
  output logic        uop_madd,
  output logic        uop_msub_1,
  output logic        uop_msub_2,
  output logic        uop_macc_1,
  output logic        uop_macc_2,
  output logic        uop_mmul_1,
  output logic        uop_mmul_2,
  output logic [63:0] accumulator,
  output logic        carry,
  output logic        ready,
  output logic [63:0] result
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_U1   = 3'd2,
    S_U2   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_MADD = 2'd0,
    OP_MSUB = 2'd1,
    OP_MACC = 2'd2,
    OP_MMUL = 2'd3
  } op_t;

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [63:0] acc_q, acc_d;
  logic        carry_q, carry_d;

  logic        any_op;
  assign any_op = op_madd | op_msub | op_macc | op_mmul;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= S_IDLE;
      op_q    <= OP_MADD;
      acc_q   <= 64'd0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    case (state_q)
      S_IDLE: begin
        // A request with no op bit set is not a legal request; ignore it.
        if (valid && any_op) begin
          if (op_madd)      op_d = OP_MADD;
          else if (op_msub) op_d = OP_MSUB;
          else if (op_macc) op_d = OP_MACC;
          else              op_d = OP_MMUL;
          acc_d   = 64'd0;
          carry_d = 1'b0;
          state_d = (!op_madd && !op_msub && !op_macc) ? S_WAIT : S_U1;
        end
      end
      S_WAIT: begin
        if (mul_done) begin
          acc_d   = mul_product;
          carry_d = 1'b0;
          state_d = S_U1;
        end
      end
      S_U1: begin
        acc_d   = n_accumulator;
        carry_d = n_carry;
        state_d = (op_q == OP_MADD) ? S_DONE : S_U2;
      end
      S_U2: begin
        acc_d   = n_accumulator;
        carry_d = n_carry;
        state_d = S_DONE;
      end
      S_DONE: begin
        // No accept here: the requester may still be holding valid from
        // the op that is completing in this cycle.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Flush overrides everything, including an accept in IDLE.
    if (flush) begin
      state_d = S_IDLE;
      acc_d   = 64'd0;
      carry_d = 1'b0;
    end
  end

  // Micro-op strobes decoded from the registered state and op
  always_comb begin
    uop_madd   = 1'b0;
    uop_msub_1 = 1'b0;
    uop_msub_2 = 1'b0;
    uop_macc_1 = 1'b0;
    uop_macc_2 = 1'b0;
    uop_mmul_1 = 1'b0;
    uop_mmul_2 = 1'b0;
    if (state_q == S_U1) begin
      case (op_q)
        OP_MADD: uop_madd   = 1'b1;
        OP_MSUB: uop_msub_1 = 1'b1;
        OP_MACC: uop_macc_1 = 1'b1;
        default: uop_mmul_1 = 1'b1;
      endcase
    end else if (state_q == S_U2) begin
      case (op_q)
        OP_MSUB: uop_msub_2 = 1'b1;
        OP_MACC: uop_macc_2 = 1'b1;
        OP_MMUL: uop_mmul_2 = 1'b1;
        default: ;
      endcase
    end
  end

  // A flush landing in the DONE cycle cancels the completion.
  assign ready       = (state_q == S_DONE) && !flush;
  assign accumulator = acc_q;
  assign carry       = carry_q;
  assign result      = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_xc_malu_long_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_xc_malu_long_seq
// Purpose  : Self-checking bench for xc_malu_long_seq. Random op patterns,
//            multiplier delays and datapath values are compared against an
//            op-level schedule model (accept, WAIT cycles, micro-ops, done).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_xc_malu_long_seq;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        valid, flush;
  logic        op_madd, op_msub, op_macc, op_mmul;
  logic        mul_done;
  logic [63:0] mul_product, n_accumulator;
  logic        n_carry;
  logic        uop_madd, uop_msub_1, uop_msub_2, uop_macc_1, uop_macc_2;
  logic        uop_mmul_1, uop_mmul_2;
  logic [63:0] accumulator, result;
  logic        carry, ready;

  int total = 0;
  int bad   = 0;

  logic [6:0] w_uop;
  assign w_uop = {uop_madd, uop_msub_1, uop_msub_2, uop_macc_1, uop_macc_2,
                  uop_mmul_1, uop_mmul_2};

  always #5 g_clk = ~g_clk;

  xc_malu_long_seq dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .valid(valid), .flush(flush),
    .op_madd(op_madd), .op_msub(op_msub), .op_macc(op_macc), .op_mmul(op_mmul),
    .mul_done(mul_done), .mul_product(mul_product),
    .n_accumulator(n_accumulator), .n_carry(n_carry),
    .uop_madd(uop_madd), .uop_msub_1(uop_msub_1), .uop_msub_2(uop_msub_2),
    .uop_macc_1(uop_macc_1), .uop_macc_2(uop_macc_2),
    .uop_mmul_1(uop_mmul_1), .uop_mmul_2(uop_mmul_2),
    .accumulator(accumulator), .carry(carry), .ready(ready), .result(result)
  );

  // Strobe expected in the first / second micro-op cycle of each op
  // (op index 0=madd 1=msub 2=macc 3=mmul; vector order as w_uop).
  function automatic logic [6:0] exp_u1(input int op);
    case (op)
      0:       return 7'b1000000;
      1:       return 7'b0100000;
      2:       return 7'b0001000;
      default: return 7'b0000010;
    endcase
  endfunction

  function automatic logic [6:0] exp_u2(input int op);
    case (op)
      1:       return 7'b0010000;
      2:       return 7'b0000100;
      default: return 7'b0000001;
    endcase
  endfunction

  task automatic set_pat(input logic [3:0] pat);
    {op_mmul, op_macc, op_msub, op_madd} = pat;
  endtask

  // Full operation from the accept cycle through DONE. Called #1 after a
  // rising edge; returns #1 after the edge that ends the DONE cycle.
  task automatic run_op(input logic [3:0] pat, input int waits, input bit keep_valid);
    int          op;
    logic [63:0] e_acc;
    logic        e_c;
    logic [63:0] prod;
    op = 0;
    for (int i = 3; i >= 0; i--) if (pat[i]) op = i;
    valid = 1'b1; set_pat(pat); mul_done = 1'b0;
    @(negedge g_clk);
    total++;
    if (w_uop !== 7'd0 || ready !== 1'b0) begin
      bad++; $display("FAIL accept_cycle pat=%b uop=%b ready=%b want uop=0 ready=0", pat, w_uop, ready);
    end
    @(posedge g_clk); #1;
    if (!keep_valid) begin
      valid = 1'b0; set_pat(4'($urandom));
    end
    e_acc = 64'd0; e_c = 1'b0;
    if (op == 3) begin
      for (int w = 1; w <= waits; w++) begin
        prod = {$urandom, $urandom};
        mul_product = prod; mul_done = (w == waits);
        @(negedge g_clk);
        total++;
        if (w_uop !== 7'd0 || ready !== 1'b0 || accumulator !== 64'd0) begin
          bad++; $display("FAIL wait_cycle w=%0d uop=%b ready=%b acc=%h want 0/0/0", w, w_uop, ready, accumulator);
        end
        if (w == waits) e_acc = prod;
        @(posedge g_clk); #1;
        mul_done = 1'b0; mul_product = {$urandom, $urandom};
      end
    end
    n_accumulator = {$urandom, $urandom}; n_carry = 1'($urandom);
    @(negedge g_clk);
    total++;
    if (w_uop !== exp_u1(op) || ready !== 1'b0 || accumulator !== e_acc || carry !== e_c) begin
      bad++; $display("FAIL uop1 op=%0d uop=%b ready=%b acc=%h c=%b want uop=%b ready=0 acc=%h c=%b",
                      op, w_uop, ready, accumulator, carry, exp_u1(op), e_acc, e_c);
    end
    e_acc = n_accumulator; e_c = n_carry;
    @(posedge g_clk); #1;
    if (op != 0) begin
      n_accumulator = {$urandom, $urandom}; n_carry = 1'($urandom);
      @(negedge g_clk);
      total++;
      if (w_uop !== exp_u2(op) || ready !== 1'b0 || accumulator !== e_acc || carry !== e_c) begin
        bad++; $display("FAIL uop2 op=%0d uop=%b ready=%b acc=%h c=%b want uop=%b ready=0 acc=%h c=%b",
                        op, w_uop, ready, accumulator, carry, exp_u2(op), e_acc, e_c);
      end
      e_acc = n_accumulator; e_c = n_carry;
      @(posedge g_clk); #1;
    end
    n_accumulator = {$urandom, $urandom}; n_carry = 1'($urandom);
    @(negedge g_clk);
    total++;
    if (ready !== 1'b1 || result !== e_acc || carry !== e_c || w_uop !== 7'd0) begin
      bad++; $display("FAIL done op=%0d ready=%b result=%h c=%b uop=%b want ready=1 result=%h c=%b uop=0",
                      op, ready, result, carry, w_uop, e_acc, e_c);
    end
    @(posedge g_clk); #1;
  endtask

  task automatic test_reset();
    g_resetn = 1'b0; valid = 1'b0; flush = 1'b0; set_pat(4'd0);
    mul_done = 1'b0; mul_product = '1; n_accumulator = '1; n_carry = 1'b1;
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    total++;
    if (w_uop !== 7'd0 || ready !== 1'b0 || accumulator !== 64'd0 || carry !== 1'b0 || result !== 64'd0) begin
      bad++; $display("FAIL reset_state uop=%b ready=%b acc=%h c=%b result=%h want all 0",
                      w_uop, ready, accumulator, carry, result);
    end
    g_resetn = 1'b1;
    @(posedge g_clk); #1;
  endtask

  task automatic test_each_op();
    run_op(4'b0001, 0, 1'b0);
    run_op(4'b0010, 0, 1'b0);
    run_op(4'b0100, 0, 1'b0);
    run_op(4'b1000, 4, 1'b0);
    run_op(4'b1000, 1, 1'b0);
  endtask

  task automatic test_random_ops();
    for (int k = 0; k < 12; k++)
      run_op(4'($urandom_range(1, 15)), $urandom_range(1, 6), 1'b0);
  endtask

  task automatic test_back_to_back();
    run_op(4'b0001, 0, 1'b1);
    run_op(4'b0010, 0, 1'b1);
    run_op(4'b1000, 2, 1'b0);
  endtask

  task automatic test_no_op();
    valid = 1'b1; set_pat(4'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge g_clk); #1;
      @(negedge g_clk);
      total++;
      if (w_uop !== 7'd0 || ready !== 1'b0) begin
        bad++; $display("FAIL no_op_accept uop=%b ready=%b want 0/0", w_uop, ready);
      end
    end
    valid = 1'b0;
    @(posedge g_clk); #1;
  endtask

  task automatic test_flush_idle();
    valid = 1'b1; set_pat(4'b0001); flush = 1'b1;
    @(posedge g_clk); #1;
    valid = 1'b0; flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge g_clk);
      total++;
      if (w_uop !== 7'd0 || ready !== 1'b0) begin
        bad++; $display("FAIL flush_blocks_accept uop=%b ready=%b want 0/0", w_uop, ready);
      end
      @(posedge g_clk); #1;
    end
  endtask

  task automatic test_flush_u2();
    valid = 1'b1; set_pat(4'b0100);
    @(posedge g_clk); #1;               // U1
    valid = 1'b0;
    n_accumulator = {1'b1, 63'($urandom)}; n_carry = 1'b1;
    @(posedge g_clk); #1;               // U2
    flush = 1'b1;
    @(posedge g_clk); #1;
    flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge g_clk);
      total++;
      if (w_uop !== 7'd0 || ready !== 1'b0 || accumulator !== 64'd0 || carry !== 1'b0) begin
        bad++; $display("FAIL flush_u2 k=%0d uop=%b ready=%b acc=%h c=%b want all 0", k, w_uop, ready, accumulator, carry);
      end
      @(posedge g_clk); #1;
    end
  endtask

  task automatic test_flush_done();
    valid = 1'b1; set_pat(4'b0001);
    @(posedge g_clk); #1;               // U1
    valid = 1'b0;
    n_accumulator = {1'b1, 63'($urandom)}; n_carry = 1'b1;
    @(posedge g_clk); #1;               // DONE
    flush = 1'b1;
    @(negedge g_clk);
    total++;
    if (ready !== 1'b0) begin
      bad++; $display("FAIL flush_done_ready ready=%b want 0", ready);
    end
    @(posedge g_clk); #1;
    flush = 1'b0;
    @(negedge g_clk);
    total++;
    if (accumulator !== 64'd0 || carry !== 1'b0 || ready !== 1'b0) begin
      bad++; $display("FAIL flush_done_clear acc=%h c=%b ready=%b want 0/0/0", accumulator, carry, ready);
    end
    @(posedge g_clk); #1;
  endtask

  task automatic test_reset_mid_op();
    // Reset in U2 of msub: strobe and accumulator are live when it hits.
    valid = 1'b1; set_pat(4'b0010);
    @(posedge g_clk); #1;
    valid = 1'b0;
    n_accumulator = {1'b1, 63'($urandom)}; n_carry = 1'b1;
    @(posedge g_clk); #2;
    g_resetn = 1'b0;
    #1;
    total++;
    if (w_uop !== 7'd0 || ready !== 1'b0 || accumulator !== 64'd0 || carry !== 1'b0 || result !== 64'd0) begin
      bad++; $display("FAIL async_reset_u2 uop=%b ready=%b acc=%h c=%b want all 0", w_uop, ready, accumulator, carry);
    end
    @(negedge g_clk); g_resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge g_clk);
      total++;
      if (ready !== 1'b0 || w_uop !== 7'd0) begin
        bad++; $display("FAIL reset_no_ready k=%0d ready=%b uop=%b want 0/0", k, ready, w_uop);
      end
    end
    // Reset during WAIT of mmul.
    @(posedge g_clk); #1;
    valid = 1'b1; set_pat(4'b1000);
    @(posedge g_clk); #1;               // WAIT
    valid = 1'b0;
    @(posedge g_clk); #1;               // still WAIT
    g_resetn = 1'b0;
    #1;
    total++;
    if (w_uop !== 7'd0 || ready !== 1'b0 || accumulator !== 64'd0) begin
      bad++; $display("FAIL async_reset_wait uop=%b ready=%b acc=%h want all 0", w_uop, ready, accumulator);
    end
    @(negedge g_clk); g_resetn = 1'b1;
    mul_done = 1'b1; mul_product = {1'b1, 63'($urandom)};
    @(posedge g_clk); #1;
    mul_done = 1'b0;
    @(negedge g_clk);
    total++;
    if (accumulator !== 64'd0 || w_uop !== 7'd0) begin
      bad++; $display("FAIL reset_left_wait acc=%h uop=%b want 0/0", accumulator, w_uop);
    end
    @(posedge g_clk); #1;
    run_op(4'b0001, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_each_op();
    test_random_ops();
    test_back_to_back();
    test_no_op();
    test_flush_idle();
    test_flush_u2();
    test_flush_done();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
